// File: rtl/axi_pkg.sv
// Shared AXI4-Lite definitions: response codes, channel FSM states and address decode.
// DEFAULT_BASE is also the reset PC used by the ifu/lsu.
package axi_pkg;

  localparam logic [31:0] DEFAULT_BASE = 32'h8000_0000;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // Wide enough for a 15-cycle latency plus 3 cycles of jitter.
  localparam int          CNT_W       = 5;
  localparam logic [7:0]  LFSR_SEED   = 8'h01;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_e;

  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned depth_log2);
    logic [33:0] limit;
    limit = {2'b00, base} + (34'd4 << depth_log2);
    return ({2'b00, addr} >= {2'b00, base}) && ({2'b00, addr} < limit);
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, loaded with seed_i on reset.
module lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [7:0] seed_i,
  output logic [7:0] state_o
);

  logic [7:0] state_q;
  logic [7:0] state_d;
  logic       fb;

  assign fb      = state_q[7] ^ state_q[5] ^ state_q[4] ^ state_q[3];
  assign state_d = en_i ? {state_q[6:0], fb} : state_q;
  assign state_o = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= seed_i;
    else      state_q <= state_d;
  end

endmodule

// File: rtl/axi_lite_sram.sv
// AXI4-Lite SRAM slave with programmable read/write latency and optional LFSR jitter.
// Read and write channels have independent FSMs; every output is a register.
module axi_lite_sram
  import axi_pkg::*;
#(
  parameter logic [31:0] BASE       = DEFAULT_BASE,
  parameter int          DEPTH_LOG2 = 16,
  parameter int          RD_LAT     = 2,
  parameter int          WR_LAT     = 2,
  parameter bit          JITTER     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  rd_state_e             r_state_q, r_state_d;
  wr_state_e             w_state_q, w_state_d;
  logic [CNT_W-1:0]      r_cnt_q, r_cnt_d, w_cnt_q, w_cnt_d;
  logic [DEPTH_LOG2-1:0] ar_idx_q, ar_idx_d, aw_idx_q, aw_idx_d;
  logic                  ar_ok_q, ar_ok_d, aw_ok_q, aw_ok_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d, bresp_q, bresp_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;

  logic [7:0]            lfsr;
  logic [CNT_W-1:0]      jit;
  logic [31:0]           ar_off, aw_off;
  logic                  ar_hs, aw_hs, w_hs, aw_have, w_have;
  logic                  r_sample, w_commit;
  logic                  unused_bits;

  lfsr8 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .en_i   (1'b1),
    .seed_i (LFSR_SEED),
    .state_o(lfsr)
  );

  assign jit      = JITTER ? CNT_W'(lfsr[1:0]) : '0;
  assign ar_off   = araddr - BASE;
  assign aw_off   = awaddr - BASE;
  assign ar_hs    = arvalid & arready_q;
  assign aw_hs    = awvalid & awready_q;
  assign w_hs     = wvalid & wready_q;
  // In W_IDLE a dropped ready means that channel has already been latched.
  assign aw_have  = aw_hs | ~awready_q;
  assign w_have   = w_hs | ~wready_q;
  assign r_sample = (r_state_q == R_WAIT) && (r_cnt_q == '0);
  assign w_commit = (w_state_q == W_WAIT) && (w_cnt_q == '0);

  assign unused_bits = ^{wstrb[7:4], ar_off[1:0], ar_off[31:DEPTH_LOG2+2],
                         aw_off[1:0], aw_off[31:DEPTH_LOG2+2], lfsr[7:2]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      r_cnt_q   <= '0;
      w_cnt_q   <= '0;
      ar_idx_q  <= '0;
      aw_idx_q  <= '0;
      ar_ok_q   <= 1'b0;
      aw_ok_q   <= 1'b0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      r_cnt_q   <= r_cnt_d;
      w_cnt_q   <= w_cnt_d;
      ar_idx_q  <= ar_idx_d;
      aw_idx_q  <= aw_idx_d;
      ar_ok_q   <= ar_ok_d;
      aw_ok_q   <= aw_ok_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_WAIT;
      R_WAIT:  if (r_cnt_q == '0) r_state_d = R_RESP;
      R_RESP:  if (rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    r_cnt_d   = r_cnt_q;
    ar_idx_d  = ar_idx_q;
    ar_ok_d   = ar_ok_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: if (ar_hs) begin
        ar_idx_d  = ar_off[DEPTH_LOG2+1:2];
        ar_ok_d   = addr_in_range(araddr, BASE, DEPTH_LOG2);
        r_cnt_d   = CNT_W'(RD_LAT) + jit;
        arready_d = 1'b0;
      end
      R_WAIT: begin
        if (r_cnt_q == '0) begin
          rvalid_d = 1'b1;
          rresp_d  = ar_ok_q ? RESP_OKAY : RESP_SLVERR;
        end else begin
          r_cnt_d = r_cnt_q - CNT_W'(1);
        end
      end
      R_RESP: if (rready) begin
        rvalid_d  = 1'b0;
        arready_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_have && w_have) w_state_d = W_WAIT;
      W_WAIT:  if (w_cnt_q == '0) w_state_d = W_RESP;
      W_RESP:  if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_d   = w_cnt_q;
    aw_idx_d  = aw_idx_q;
    aw_ok_d   = aw_ok_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_idx_d  = aw_off[DEPTH_LOG2+1:2];
          aw_ok_d   = addr_in_range(awaddr, BASE, DEPTH_LOG2);
          awready_d = 1'b0;
        end
        if (w_hs) begin
          wdata_d  = wdata;
          wstrb_d  = wstrb[3:0];
          wready_d = 1'b0;
        end
        if (aw_have && w_have) w_cnt_d = CNT_W'(WR_LAT) + jit;
      end
      W_WAIT: begin
        if (w_cnt_q == '0) begin
          bvalid_d = 1'b1;
          bresp_d  = aw_ok_q ? RESP_OKAY : RESP_SLVERR;
        end else begin
          w_cnt_d = w_cnt_q - CNT_W'(1);
        end
      end
      W_RESP: if (bready) begin
        bvalid_d  = 1'b0;
        awready_d = 1'b1;
        wready_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // One byte-wide RAM per lane; a same-cycle read of a committing word sees old data.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane [WORDS];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
        if (w_commit && aw_ok_q && wstrb_q[gi]) lane[aw_idx_q] <= wdata_q[8*gi +: 8];
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)          rd_q <= 8'h00;
        else if (r_sample) rd_q <= ar_ok_q ? lane[ar_idx_q] : 8'h00;
      end

      assign rdata[8*gi +: 8] = rd_q;
    end
  endgenerate

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

endmodule
